// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter in front of a FIFO write stream.
// Grant is held until end of packet or MAX_BURST beats.
module axis_rr_arbiter #(
   parameter int N_PORTS   = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 64,
   localparam int IDX_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
   localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_PORTS*DATA_W-1:0] in_data,
   input  logic [N_PORTS-1:0]        in_valid,
   input  logic [N_PORTS-1:0]        in_last,
   output logic [N_PORTS-1:0]        in_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   output logic                      out_last,
   input  logic                      out_ready,
   input  logic                      fifo_prog_full,
   output logic                      grant_active,
   output logic [IDX_W-1:0]          grant_idx,
   output logic [31:0]               pkt_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  pick;
   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  g_nxt;
   logic [CNT_W-1:0]  beat_cnt;
   logic              found;
   logic              ok;
   logic              cap_hit;
   logic              done;
   int                scan_j;
   logic [DATA_W-1:0] port_data [N_PORTS];

   for (genvar i = 0; i < N_PORTS; i++) begin : g_split
      assign port_data[i] = in_data[i*DATA_W +: DATA_W];
   end

   // First requester at or above rr_ptr, wrapping modulo N_PORTS.
   always_comb begin
      found  = 1'b0;
      pick   = '0;
      cand   = '0;
      scan_j = 0;
      for (int k = 0; k < N_PORTS; k++) begin
         scan_j = int'(rr_ptr) + k;
         if (scan_j >= N_PORTS)
            scan_j = scan_j - N_PORTS;
         cand = IDX_W'(scan_j);
         if (!found && in_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      out_valid = 1'b0;
      out_data  = port_data[grant_idx];
      out_last  = in_last[grant_idx];
      in_ready  = '0;
      if (state == BUSY) begin
         out_valid           = in_valid[grant_idx];
         in_ready[grant_idx] = out_ready;
      end
   end

   assign grant_active = (state == BUSY);
   assign ok           = out_valid & out_ready;
   assign cap_hit      = (beat_cnt == CNT_W'(MAX_BURST - 1));
   assign done         = ok & (out_last | cap_hit);
   assign g_nxt        = (grant_idx == IDX_W'(N_PORTS - 1)) ?
                         '0 : grant_idx + 1'b1;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (found && !fifo_prog_full) state_nxt = BUSY;
         BUSY: if (done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         grant_idx <= '0;
         beat_cnt  <= '0;
         pkt_count <= '0;
      end else begin
         if (state == IDLE && state_nxt == BUSY) begin
            grant_idx <= pick;
            beat_cnt  <= '0;
         end
         if (ok)
            beat_cnt <= beat_cnt + 1'b1;
         if (done)
            rr_ptr <= g_nxt;
         if (ok && out_last)
            pkt_count <= pkt_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized bench for axis_rr_arbiter against a
// transaction-level model of the arbitration rules.
module tb_axis_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int MB = 4;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP*DW-1:0] in_data;
   logic [NP-1:0]    in_valid;
   logic [NP-1:0]    in_last;
   logic [NP-1:0]    in_ready;
   logic [DW-1:0]    out_data;
   logic             out_valid;
   logic             out_last;
   logic             out_ready;
   logic             fifo_prog_full;
   logic             grant_active;
   logic [IW-1:0]    grant_idx;
   logic [31:0]      pkt_count;

   always #5 clk = ~clk;

   axis_rr_arbiter #(
      .N_PORTS(NP), .DATA_W(DW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .out_ready(out_ready),
      .fifo_prog_full(fifo_prog_full),
      .grant_active(grant_active),
      .grant_idx(grant_idx), .pkt_count(pkt_count)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Source streams: each port walks through packets beat by beat.
   int s_len  [NP];
   int s_beat [NP];
   int s_pkt  [NP];
   int fix_len[NP];
   int len_max;
   int v_mask, v_pct, r_pct, pf_pct, rst_pct;

   // Reference model state.
   bit          m_busy;
   int          m_idx, m_ptr, m_beats;
   logic [31:0] m_pkts;

   function automatic int new_len(input int p);
      return (fix_len[p] > 0) ? fix_len[p] : $urandom_range(len_max, 1);
   endfunction

   function automatic logic [DW-1:0] word(input int p);
      logic [DW-1:0] w;
      w = {p[3:0], s_pkt[p][15:0], s_beat[p][11:0]};
      return w;
   endfunction

   task automatic phase(input int vm, input int vp, input int rp,
                        input int pp, input int xp, input int lm);
      v_mask = vm; v_pct = vp; r_pct = rp;
      pf_pct = pp; rst_pct = xp; len_max = lm;
      for (int p = 0; p < NP; p++)
         if (s_beat[p] == 0) s_len[p] = new_len(p);
   endtask

   task automatic model_reset();
      m_busy = 0; m_idx = 0; m_ptr = 0; m_beats = 0; m_pkts = '0;
   endtask

   task automatic step(input string ph);
      logic [NP-1:0] er;
      bit ev, ok, lst;
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
         in_data[p*DW +: DW] = word(p);
         in_last[p]  = (s_beat[p] == s_len[p] - 1);
         in_valid[p] = v_mask[p] && ($urandom_range(99, 0) < v_pct);
      end
      out_ready      = ($urandom_range(99, 0) < r_pct);
      fifo_prog_full = ($urandom_range(99, 0) < pf_pct);
      rst            = ($urandom_range(99, 0) < rst_pct);
      #1;
      ev = m_busy && in_valid[m_idx];
      er = '0;
      if (m_busy) er[m_idx] = out_ready;
      chk({ph, "/active"}, 64'(grant_active), 64'(m_busy));
      chk({ph, "/idx"},    64'(grant_idx),    64'(m_idx));
      chk({ph, "/pkts"},   64'(pkt_count),    64'(m_pkts));
      chk({ph, "/valid"},  64'(out_valid),    64'(ev));
      chk({ph, "/ready"},  64'(in_ready),     64'(er));
      if (ev) begin
         chk({ph, "/data"}, 64'(out_data), 64'(word(m_idx)));
         chk({ph, "/last"}, 64'(out_last), 64'(in_last[m_idx]));
      end
      ok  = ev && out_ready;
      lst = ok && in_last[m_idx];
      if (ok) begin
         s_beat[m_idx]++;
         if (s_beat[m_idx] == s_len[m_idx]) begin
            s_beat[m_idx] = 0;
            s_pkt[m_idx]++;
            s_len[m_idx] = new_len(m_idx);
         end
      end
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         if (!fifo_prog_full) begin
            for (int k = NP - 1; k >= 0; k--)
               if (in_valid[(m_ptr + k) % NP]) begin
                  m_idx  = (m_ptr + k) % NP;
                  m_busy = 1;
               end
            m_beats = 0;
         end
      end else if (ok) begin
         m_beats++;
         if (lst) m_pkts++;
         if (lst || m_beats == MB) begin
            m_busy = 0;
            m_ptr  = (m_idx + 1) % NP;
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0;
      out_ready = 1'b0; fifo_prog_full = 1'b0;
      for (int p = 0; p < NP; p++) begin
         s_beat[p] = 0; s_pkt[p] = 0; fix_len[p] = 0; s_len[p] = 1;
      end
      repeat (2) @(posedge clk);
      model_reset();
      phase(4'hF, 100, 100, 0, 100, 3);
      repeat (2) step("reset");
      fix_len[0] = 3;
      phase(4'h1, 100, 100, 0, 0, 3);
      repeat (12) step("single");
      for (int p = 0; p < NP; p++) fix_len[p] = 1;
      phase(4'hF, 100, 100, 0, 0, 1);
      repeat (16) step("all1");
      fix_len[2] = 10; fix_len[3] = 0;
      phase(4'hC, 100, 100, 0, 0, 3);
      repeat (60) step("cap");
      fix_len[2] = 0; fix_len[0] = 0; fix_len[1] = 0;
      phase(4'h3, 100, 100, 60, 0, 5);
      repeat (80) step("pfull");
      phase(4'hF, 80, 50, 0, 0, 6);
      repeat (200) step("ready");
      phase(4'hF, 70, 70, 25, 0, 8);
      repeat (600) step("mix");
      phase(4'hF, 75, 75, 15, 3, 6);
      repeat (600) step("rst");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
